// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with registered one-hot grant and burst tenure; WRR_LOCK_EN adds a lock input
module wrr_arbiter #(
    parameter int REQ_WIDTH    = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int IDX_WIDTH    = $clog2(REQ_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ready_in,
    input  logic [REQ_WIDTH-1:0]            req,
    input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
`ifdef WRR_LOCK_EN
    input  logic                            lock,
`endif
    output logic [REQ_WIDTH-1:0]            grant,
    output logic                            grant_valid,
    output logic [IDX_WIDTH-1:0]            grant_idx
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [REQ_WIDTH-1:0] grant_n, ptr_mask, ptr_mask_n, above;
    logic [IDX_WIDTH-1:0] grant_idx_n, w;
    logic [WEIGHT_WIDTH-1:0] credit, credit_n;
    logic [IDX_WIDTH:0] win_idle, win_end, win;
    logic beat, hold, tenure_end, load;

    // Lowest set bit of the masked requests, falling back to all requests; MSB flags a winner
    function automatic logic [IDX_WIDTH:0] pick(input logic [REQ_WIDTH-1:0] r, input logic [REQ_WIDTH-1:0] m);
        logic [REQ_WIDTH-1:0] c;
        c = (|(r & m)) ? (r & m) : r;
        pick = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--)
            if (c[i]) pick = {1'b1, IDX_WIDTH'(i)};
    endfunction

`ifdef WRR_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    assign grant_valid = |grant;
    assign beat        = grant_valid && ready_in && req[grant_idx];
    assign tenure_end  = (state == GRANT) && ((beat && credit == '0 && !hold) || !req[grant_idx]);
    assign win_idle    = pick(req, ptr_mask);
    assign win_end     = pick(req, above);
    assign win         = (state == IDLE) ? win_idle : win_end;
    assign w           = win[IDX_WIDTH-1:0];
    assign load        = ((state == IDLE) || tenure_end) && win[IDX_WIDTH];

    // Rotation mask for the next tenure: only requesters strictly above the current holder
    always_comb begin
        above = '0;
        for (int i = 0; i < REQ_WIDTH; i++)
            above[i] = IDX_WIDTH'(i) > grant_idx;
    end

    // Next-state: start/hand over tenures, count down credit, or freeze on a stalled beat
    always_comb begin
        state_n     = state;
        grant_n     = grant;
        grant_idx_n = grant_idx;
        credit_n    = credit;
        ptr_mask_n  = tenure_end ? above : ptr_mask;
        if (load) begin
            state_n     = GRANT;
            grant_n     = REQ_WIDTH'(1) << w;
            grant_idx_n = w;
            credit_n    = weight[w*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end else if (tenure_end) begin
            state_n = IDLE;
            grant_n = '0;
        end else if (beat && credit != '0) begin
            credit_n = credit - 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            credit    <= '0;
            ptr_mask  <= '1;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            grant_idx <= grant_idx_n;
            credit    <= credit_n;
            ptr_mask  <= ptr_mask_n;
        end
    end
endmodule
